wbu_exec: RTL
=============

Name: wbu_exec

Overview:
- Bus-master execution stage directly downstream of the serial codeword reader.
- Consumes 36-bit command codewords (set address, write, vector read) and runs the matching Wishbone pipelined bus cycles.
- Returns 36-bit response codewords for the host-bound output path.
- Single clock domain; one outstanding command at a time.

Parameters:
- TIMEOUT_LGCYC, 16: log2 of bus-cycle watchdog length in clocks.
- AW, 32: Wishbone address width; addresses are 32 bits internally, truncated to AW at the port.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_stb  in  1  codeword valid, single-cycle pulse
- i_codword  in  36  command codeword, [35] first-received bit
- o_busy  out  1  high while a command is executing
- o_overflow  out  1  one-cycle pulse: i_stb arrived while o_busy, codeword discarded
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  bus strobe
- o_wb_we  out  1  write enable
- o_wb_addr  out  AW  bus address
- o_wb_data  out  32  write data
- i_wb_ack  in  1  bus ack
- i_wb_stall  in  1  bus stall
- i_wb_err  in  1  bus error
- i_wb_data  in  32  read data
- o_rsp_stb  out  1  response valid, one-cycle pulse
- o_rsp_word  out  36  response codeword

Behaviour:
- Reset: all outputs 0; address register 0; increment enabled; state IDLE.
- Command decode, accepted only when i_stb and IDLE:
  - cw[35:33]=000: set address = cw[31:0]; cw[32]=1 disables post-increment, 0 enables it.
  - cw[35:33]=001: relative address.
    - Length L = 2 + cw[32:31].
    - Signed offset field cw[30:36-6L] (7/13/19/25 bits), sign-extended to 32 bits and added to address, mod 2^32.
  - cw[35:33]=011: write cw[31:0].
  - cw[35:33]=010: short write; value = sign-extended cw[32:24].
  - cw[35:34]=10: 1-hexbit read.
    - Count = cw[33:30]+1 for 0x0–0xD.
    - 0xE and 0xF are reserved: ignored, no response, no state change.
  - cw[35:34]=11: 2-hexbit read; count = cw[33:24]+1 (1..1024).
- States:
  - IDLE → ADDR (one cycle, emit response) → IDLE.
  - IDLE → WRITE → WAIT → IDLE.
  - IDLE → READ → WAIT → IDLE.
- Latency:
  - Command accepted at cycle N.
  - Set/relative address: o_rsp_stb at N+1, word {4'h0, new address}.
  - Bus commands: o_wb_cyc and o_wb_stb high at N+1.
- o_busy: high from N+1 until the cycle after the final response; o_overflow pulses if i_stb arrives while o_busy.
- WRITE:
  - One strobe, held while i_wb_stall.
  - Once the strobe is accepted (stb && !stall): drop stb; if increment enabled, address +1 on that cycle.
  - Ack: o_wb_cyc drops next cycle; response {4'h1, 32'h0} on that same cycle.
- READ:
  - Pipelined; stb stays high until `count` strobes are accepted.
  - Address +1 per accepted strobe when increment is enabled.
  - Ack counter runs separately.
  - Each ack at cycle M gives o_rsp_stb at M+1, word {4'h2, i_wb_data}.
  - Cycle ends the cycle after the count-th ack.
  - Ack and strobe acceptance in the same cycle are both counted.
- Error: i_wb_err in any bus state aborts.
  - stb and cyc drop next cycle; response {4'h3, current address}.
  - Remaining strobes are cancelled; later acks are ignored.
  - Address holds its value after the last accepted strobe.
- Watchdog:
  - Counter clears on accept or ack; counts while cyc is high.
  - At 2^TIMEOUT_LGCYC-1 clocks: abort as for error, response {4'h4, current address}.
- Simultaneous ack and err in one cycle: err wins; no read-data response for that cycle.
- Reset asserted mid-transaction: cyc/stb drop immediately (asynchronous); no response issued.
- o_wb_we: set with cyc for writes, cleared in IDLE.
- o_wb_data: loaded at command accept.

Test Plan:
- Set address 36'h0_0000_1000, then 1-hexbit read cw[35:30]=6'h23 (count 4) with always-ack → bus addresses 0x1000–0x1003 strobed on 4 consecutive cycles; 4 responses {4'h2, data}; final address 0x1004.
- Set address with cw[32]=1 to 0x20, then short write cw[35:24]=12'h5FF → write 0xFFFFFFFF to 0x20; response 36'h1_0000_0000; address stays 0x20.
- Address 0x100, relative L=2 offset 7'h7F → response 36'h0_0000_00FF; offset 7'h01 → 36'h0_0000_0101.
- 2-hexbit read count 3, i_wb_stall high on the second strobe for 5 cycles, acks delayed 2 cycles → exactly 3 strobes accepted, 3 ordered responses, cyc low after the 3rd ack.
- Read count 8, i_wb_err on the 3rd ack → 2 data responses, then {4'h3, addr}; cyc low next cycle; extra acks ignored; i_stb during the command → o_overflow pulse.
- Write with ack never returned, TIMEOUT_LGCYC=4 → abort after 15 clocks, response {4'h4, addr}; i_rst asserted mid-read → all outputs 0 on the same edge.

Source files
------------

// File: rtl/wbu_exec.sv
// Bus-master execution stage: decodes 36-bit command codewords, runs Wishbone
// pipelined cycles and returns 36-bit response codewords.
module wbu_exec #(
   parameter int unsigned TIMEOUT_LGCYC = 16,
   parameter int unsigned AW            = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_stb,
   input  logic [35:0]   i_codword,
   output logic          o_busy,
   output logic          o_overflow,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [AW-1:0] o_wb_addr,
   output logic [31:0]   o_wb_data,
   input  logic          i_wb_ack,
   input  logic          i_wb_stall,
   input  logic          i_wb_err,
   input  logic [31:0]   i_wb_data,
   output logic          o_rsp_stb,
   output logic [35:0]   o_rsp_word
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WRITE, S_READ, S_WAIT} state_t;

   state_t                   state, state_nxt;
   logic [31:0]              addr;
   logic                     inc;
   logic [10:0]              stb_left, ack_left;
   logic [TIMEOUT_LGCYC-1:0] wdog;

   logic        op_set, op_rel, op_wr, op_swr, op_rd;
   logic        take, in_bus, abort, stb_acc, ack_ok;
   logic [31:0] rel_off, new_addr;
   logic [10:0] rd_cnt;

   always_comb begin
      op_set = (i_codword[35:33] == 3'b000);
      op_rel = (i_codword[35:33] == 3'b001);
      op_swr = (i_codword[35:33] == 3'b010);
      op_wr  = (i_codword[35:33] == 3'b011);
      // 1-hexbit counts 0xE/0xF are reserved and silently dropped
      op_rd  = ((i_codword[35:34] == 2'b10) && (i_codword[33:30] < 4'hE))
             || (i_codword[35:34] == 2'b11);
      rd_cnt = i_codword[34] ? ({1'b0, i_codword[33:24]} + 11'd1)
                             : ({7'd0, i_codword[33:30]} + 11'd1);
      case (i_codword[32:31])
         2'd0:    rel_off = {{25{i_codword[30]}}, i_codword[30:24]};
         2'd1:    rel_off = {{19{i_codword[30]}}, i_codword[30:18]};
         2'd2:    rel_off = {{13{i_codword[30]}}, i_codword[30:12]};
         default: rel_off = {{7{i_codword[30]}},  i_codword[30:6]};
      endcase
      new_addr = op_set ? i_codword[31:0] : (addr + rel_off);
   end

   assign o_busy    = (state != S_IDLE) || o_rsp_stb;
   assign o_wb_addr = addr[AW-1:0];

   always_comb begin
      take    = i_stb && !o_busy && (op_set || op_rel || op_wr || op_swr || op_rd);
      in_bus  = (state == S_WRITE) || (state == S_READ) || (state == S_WAIT);
      abort   = in_bus && (i_wb_err || (&wdog));
      stb_acc = in_bus && o_wb_stb && !i_wb_stall && !abort;
      ack_ok  = in_bus && i_wb_ack && !abort;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (take) begin
               if (op_set || op_rel)     state_nxt = S_ADDR;
               else if (op_wr || op_swr) state_nxt = S_WRITE;
               else                      state_nxt = S_READ;
            end
         S_ADDR: state_nxt = S_IDLE;
         S_WRITE, S_READ, S_WAIT:
            if (abort || (ack_ok && (ack_left == 11'd1)))  state_nxt = S_IDLE;
            else if (stb_acc && (stb_left == 11'd1))       state_nxt = S_WAIT;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr       <= '0;
         inc        <= 1'b1;
         stb_left   <= '0;
         ack_left   <= '0;
         wdog       <= '0;
         o_overflow <= 1'b0;
         o_wb_cyc   <= 1'b0;
         o_wb_stb   <= 1'b0;
         o_wb_we    <= 1'b0;
         o_wb_data  <= '0;
         o_rsp_stb  <= 1'b0;
         o_rsp_word <= '0;
      end else begin
         o_rsp_stb  <= 1'b0;
         o_overflow <= i_stb && o_busy;

         if (take || stb_acc || ack_ok) wdog <= '0;
         else if (o_wb_cyc)             wdog <= wdog + 1'b1;

         if (take) begin
            if (op_set || op_rel) begin
               addr       <= new_addr;
               o_rsp_stb  <= 1'b1;
               o_rsp_word <= {4'h0, new_addr};
               if (op_set) inc <= !i_codword[32];
            end else begin
               o_wb_cyc <= 1'b1;
               o_wb_stb <= 1'b1;
               o_wb_we  <= !op_rd;
               stb_left <= op_rd ? rd_cnt : 11'd1;
               ack_left <= op_rd ? rd_cnt : 11'd1;
               if (op_wr)       o_wb_data <= i_codword[31:0];
               else if (op_swr) o_wb_data <= {{23{i_codword[32]}}, i_codword[32:24]};
            end
         end

         if (stb_acc) begin
            addr     <= addr + {31'd0, inc};
            stb_left <= stb_left - 11'd1;
            if (stb_left == 11'd1) o_wb_stb <= 1'b0;
         end

         // strobe and ack counters advance independently in the same cycle
         if (ack_ok) begin
            ack_left   <= ack_left - 11'd1;
            o_rsp_stb  <= 1'b1;
            o_rsp_word <= o_wb_we ? {4'h1, 32'h0} : {4'h2, i_wb_data};
            if (ack_left == 11'd1) begin
               o_wb_cyc <= 1'b0;
               o_wb_stb <= 1'b0;
               o_wb_we  <= 1'b0;
            end
         end

         if (abort) begin
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_rsp_stb  <= 1'b1;
            o_rsp_word <= {(i_wb_err ? 4'h3 : 4'h4), addr};
         end
      end
   end

endmodule
